// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit and datapath.
// Holds state codes, opcode/funct constants, ALU codes and mux selects.
package mips_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   ||
               (op == OP_SW)    || (op == OP_BEQ)  ||
               (op == OP_ADDI)  || (op == OP_ANDI) ||
               (op == OP_ORI)   || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// ALU operation decode for the multicycle controller.
// in: opcode, funct, state; out: alu_control, ext_zero, funct_illegal.
module mips_alu_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int ALUCW = 4
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  state_t           state,
    output logic [ALUCW-1:0] alu_control,
    output logic             ext_zero,
    output logic             funct_illegal
);

    always_comb begin
        alu_control   = '0;
        ext_zero      = 1'b0;
        funct_illegal = 1'b0;
        unique case (state)
            // PC+4 in fetch, branch target in decode
            S_FETCH, S_DECODE: alu_control = ALU_ADD;
            S_EXEC: begin
                unique case (opcode)
                    OP_RTYPE: begin
                        unique case (funct)
                            FN_ADD:  alu_control = ALU_ADD;
                            FN_SUB:  alu_control = ALU_SUB;
                            FN_AND:  alu_control = ALU_AND;
                            FN_OR:   alu_control = ALU_OR;
                            FN_SLT:  alu_control = ALU_SLT;
                            FN_SLL:  alu_control = ALU_SLL;
                            FN_SRL:  alu_control = ALU_SRL;
                            default: funct_illegal = 1'b1;
                        endcase
                    end
                    OP_LW, OP_SW, OP_ADDI: alu_control = ALU_ADD;
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        ext_zero    = 1'b1;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        ext_zero    = 1'b1;
                    end
                    OP_BEQ:  alu_control = ALU_SUB;
                    default: alu_control = '0;
                endcase
            end
            default: alu_control = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS datapath (fetch..writeback).
// in: clk, reset, init, opcode, funct, alu_zero, mem_ack; out: all enables/selects.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int ALUCW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [ALUCW-1:0] alu_control,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             halted
);

    state_t state;
    logic   funct_ill;
    logic   live;
    logic   ack;
    logic   is_r, is_lw, is_sw, is_beq, is_j;

    // init abandons the instruction: no commit, and it beats mem_ack
    assign live = ~init;
    assign ack  = mem_ack & ~init;

    assign is_r   = (opcode == OP_RTYPE);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);

    mips_alu_decode #(
        .OPW   (OPW),
        .ALUCW (ALUCW)
    ) u_alu_decode (
        .opcode        (opcode),
        .funct         (funct),
        .state         (state),
        .alu_control   (alu_control),
        .ext_zero      (ext_zero),
        .funct_illegal (funct_ill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (init && state != S_HALT) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (mem_ack) state <= S_DECODE;
                S_DECODE: begin
                    if (is_j)
                        state <= S_FETCH;
                    else if (op_supported(opcode))
                        state <= S_EXEC;
                    else
                        state <= S_HALT;
                end
                S_EXEC: begin
                    unique case (1'b1)
                        funct_ill:      state <= S_HALT;
                        is_lw | is_sw:  state <= S_MEM;
                        is_beq:         state <= S_FETCH;
                        default:        state <= S_WB;
                    endcase
                end
                S_MEM: if (mem_ack) state <= is_sw ? S_FETCH : S_WB;
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_iord   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_PC4;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REG;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = ack;
                pc_write  = ack;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMMSH;
                if (is_j) begin
                    pc_src     = PCSRC_JMP;
                    pc_write   = live;
                    instr_done = live;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (is_r | is_beq) ? ALUB_REG : ALUB_IMM;
                if (is_beq) begin
                    pc_src     = PCSRC_BR;
                    pc_write   = alu_zero & live;
                    instr_done = live;
                end
            end
            S_MEM: begin
                mem_req    = 1'b1;
                mem_iord   = 1'b1;
                mem_we     = is_sw;
                instr_done = ack & is_sw;
            end
            S_WB: begin
                reg_write  = live;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                instr_done = live;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
// Steps through reset, add, lw with waits, beq, j, andi, sw, halt and init abort.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, init, alu_zero, mem_ack;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, mem_iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, ext_zero;
    logic [3:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, halted;
    logic [19:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_iord    (mem_iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ext_zero    (ext_zero),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    assign outs = {mem_req, mem_we, mem_iord, ir_write, pc_write,
                   pc_src, alu_src_a, alu_src_b, ext_zero, alu_control,
                   reg_write, reg_dst, mem_to_reg, instr_done, halted};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ack();
        mem_ack = 1'b1;
        #1;
        chk("fetch_req", {31'd0, mem_req}, 1);
        chk("fetch_irw", {30'd0, ir_write, pc_write}, 3);
        chk("fetch_done", {31'd0, instr_done}, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; init = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0;
        opcode = 6'd0; funct = 6'd0;
        tick(); tick();
        #1;
        chk("reset_outs", {12'd0, outs}, 0);
        reset = 1'b0;
        tick();
        #1;
        chk("post_reset_req", {31'd0, mem_req}, 1);
        chk("post_reset_iord", {31'd0, mem_iord}, 0);
        chk("post_reset_alu", {28'd0, alu_control}, 4'b0010);
        chk("post_reset_b", {30'd0, alu_src_b}, 2'b01);
        chk("post_reset_irw", {31'd0, ir_write}, 0);

        // add: FETCH, DECODE, EXEC, WB
        fetch_ack();
        opcode = 6'b000000; funct = 6'b100000;
        #1;
        chk("add_dec_b", {30'd0, alu_src_b}, 2'b11);
        chk("add_dec_pcw", {30'd0, ir_write, pc_write}, 0);
        chk("add_dec_done", {31'd0, instr_done}, 0);
        tick(); #1;
        chk("add_exe_alu", {28'd0, alu_control}, 4'b0010);
        chk("add_exe_ab", {29'd0, alu_src_a, alu_src_b}, 3'b100);
        chk("add_exe_done", {31'd0, instr_done}, 0);
        tick(); #1;
        chk("add_wb", {28'd0, reg_write, reg_dst, mem_to_reg, instr_done},
            4'b1101);
        tick();

        // lw with 3 wait cycles in FETCH and MEM: 11 cycles
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_fwait", {29'd0, mem_req, ir_write, instr_done}, 3'b100);
            tick();
        end
        fetch_ack();
        mem_ack = 1'b0;
        opcode = 6'b100011;
        #1;
        chk("lw_dec_done", {31'd0, instr_done}, 0);
        tick(); #1;
        chk("lw_exe_ab", {29'd0, alu_src_a, alu_src_b}, 3'b110);
        chk("lw_exe_alu", {28'd0, alu_control}, 4'b0010);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_mwait", {28'd0, mem_req, mem_iord, mem_we, instr_done},
                4'b1100);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        chk("lw_mem_ack", {28'd0, mem_req, mem_iord, mem_we, instr_done},
            4'b1100);
        tick(); #1;
        chk("lw_wb", {28'd0, reg_write, reg_dst, mem_to_reg, instr_done},
            4'b1011);
        tick();

        // beq taken
        fetch_ack();
        opcode = 6'b000100;
        tick();
        alu_zero = 1'b1;
        #1;
        chk("beq1_pc", {28'd0, pc_write, instr_done, pc_src}, 4'b1101);
        chk("beq1_alu", {28'd0, alu_control}, 4'b0110);
        tick(); #1;
        chk("beq1_next_fetch", {31'd0, mem_req}, 1);

        // beq not taken
        fetch_ack();
        tick();
        alu_zero = 1'b0;
        #1;
        chk("beq0_pc", {28'd0, pc_write, instr_done, pc_src}, 4'b0101);
        tick();

        // j: 2 cycles
        fetch_ack();
        opcode = 6'b000010;
        #1;
        chk("j_dec", {28'd0, pc_write, instr_done, pc_src}, 4'b1110);
        tick(); #1;
        chk("j_next_fetch", {31'd0, mem_req}, 1);

        // andi: zero-extend, and
        fetch_ack();
        opcode = 6'b001100;
        tick(); #1;
        chk("andi_exe", {27'd0, ext_zero, alu_control}, 5'b10000);
        tick(); #1;
        chk("andi_wb", {28'd0, reg_write, reg_dst, mem_to_reg, instr_done},
            4'b1001);
        tick();

        // srl via R-type
        fetch_ack();
        opcode = 6'b000000; funct = 6'b000010;
        tick(); #1;
        chk("srl_exe", {28'd0, alu_control}, 4'b1001);
        tick(); tick();

        // sw completes in MEM
        fetch_ack();
        opcode = 6'b101011;
        tick(); tick(); #1;
        chk("sw_mem", {28'd0, mem_req, mem_iord, mem_we, instr_done},
            4'b1111);
        tick();

        // sw abandoned by init during MEM
        fetch_ack();
        tick(); tick();
        init = 1'b1;
        #1;
        chk("sw_init_done", {31'd0, instr_done}, 0);
        tick(); #1;
        chk("init_idle", {12'd0, outs}, 0);
        tick(); #1;
        chk("init_hold", {12'd0, outs}, 0);
        init = 1'b0;
        tick(); #1;
        chk("init_release", {30'd0, mem_req, mem_iord}, 2'b10);

        // illegal opcode -> HALT
        fetch_ack();
        opcode = 6'b111111;
        #1;
        chk("ill_dec_done", {31'd0, instr_done}, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            init = (i >= 10 && i < 13);
            #1;
            chk("halt_outs", {12'd0, outs}, 20'h1);
            tick();
        end
        init = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("halt_reset", {12'd0, outs}, 0);
        tick();

        // illegal funct -> HALT after EXEC
        fetch_ack();
        opcode = 6'b000000; funct = 6'b111111;
        tick(); tick(); #1;
        chk("bad_funct_halt", {31'd0, halted}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
